// File: rtl/chal_load_ctrl.sv
// Challenge scan sequencer: stages a host-written challenge, shifts it MSB-first into the
// external challenge register while capturing the old contents, then runs an eval window.
module chal_load_ctrl #(
  parameter int CHAL_BITS   = 128,
  parameter int DIV         = 1,
  parameter int EVAL_CYCLES = 16,
  parameter int AW          = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          eval,
  output logic          chal_clk,
  output logic          chal_si,
  input  logic          chal_so
);

  localparam int WORDS = CHAL_BITS / 32;
  localparam int BCW   = $clog2(CHAL_BITS) + 1;
  localparam int DCW   = $clog2(DIV) + 1;
  localparam int ECW   = $clog2(EVAL_CYCLES) + 1;

  localparam logic [BCW-1:0] BIT_LAST  = BCW'(CHAL_BITS);
  localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
  localparam logic [ECW-1:0] EVAL_LAST = ECW'(EVAL_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, EVAL, DONE} state_t;

  state_t                 state_q, state_d;
  logic [DCW-1:0]         div_cnt_q, div_cnt_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [ECW-1:0]         eval_cnt_q, eval_cnt_d;
  logic [CHAL_BITS-1:0]   staging_q, staging_d, staging_wr;
  logic [CHAL_BITS-1:0]   capture_q, capture_d;
  logic                   chal_clk_q, chal_clk_d;
  logic                   chal_si_q, chal_si_d;
  logic [31:0]            rd_words [2**AW];

  // Host writes only take effect while idle; the gate lives here so the FSM can use the result directly.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_stage_wr
    assign staging_wr[gi*32 +: 32] =
        (wr_en && state_q == IDLE && wr_addr == AW'(gi)) ? wr_data : staging_q[gi*32 +: 32];
  end

  for (genvar gi = 0; gi < 2**AW; gi++) begin : g_rd_words
    if (gi < WORDS) begin : g_used
      assign rd_words[gi] = capture_q[gi*32 +: 32];
    end else begin : g_pad
      assign rd_words[gi] = '0;
    end
  end

  assign rd_data  = rd_words[rd_addr];
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign eval     = (state_q == EVAL);
  assign chal_clk = chal_clk_q;
  assign chal_si  = chal_si_q;

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    eval_cnt_d = eval_cnt_q;
    staging_d  = staging_q;
    capture_d  = capture_q;
    case (state_q)
      IDLE: begin
        staging_d = staging_wr;
        if (start) begin
          state_d   = SHIFT_LO;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      SHIFT_LO: begin
        if (div_cnt_q == DIV_LAST) begin
          // chal_so still shows the bit ahead of the rising edge issued at this clock edge.
          capture_d = {capture_q[CHAL_BITS-2:0], chal_so};
          div_cnt_d = '0;
          state_d   = SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div_cnt_q == DIV_LAST) begin
          staging_d = {staging_q[CHAL_BITS-2:0], staging_q[CHAL_BITS-1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          div_cnt_d = '0;
          if (bit_cnt_d == BIT_LAST) begin
            state_d    = EVAL;
            eval_cnt_d = '0;
          end else begin
            state_d = SHIFT_LO;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      EVAL: begin
        if (eval_cnt_q == EVAL_LAST) begin
          state_d = DONE;
        end else begin
          eval_cnt_d = eval_cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Both scan outputs come from flops; chal_si only reloads on entry to the low phase.
    chal_clk_d = (state_d == SHIFT_HI);
    chal_si_d  = (state_d == SHIFT_LO) ? staging_d[CHAL_BITS-1] : chal_si_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      eval_cnt_q <= '0;
      staging_q  <= '0;
      capture_q  <= '0;
      chal_clk_q <= 1'b0;
      chal_si_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      eval_cnt_q <= eval_cnt_d;
      staging_q  <= staging_d;
      capture_q  <= capture_d;
      chal_clk_q <= chal_clk_d;
      chal_si_q  <= chal_si_d;
    end
  end

endmodule

// File: tb/tb_chal_load_ctrl.sv
// Directed bench for chal_load_ctrl: a 128-bit DIV=1 build and a 32-bit DIV=3 build,
// each driving a behavioural model of the external challenge shift register.
module tb_chal_load_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 128-bit, DIV=1 build
  logic        rstn_a, wr_en_a, start_a, chal_so_a;
  logic [1:0]  wr_addr_a, rd_addr_a;
  logic [31:0] wr_data_a, rd_data_a;
  logic        busy_a, done_a, eval_a, chal_clk_a, chal_si_a;

  chal_load_ctrl #(.CHAL_BITS(128), .DIV(1), .EVAL_CYCLES(16), .AW(2)) u_dut_a (
    .clk(clk), .rstn(rstn_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .start(start_a), .busy(busy_a), .done(done_a),
    .eval(eval_a), .chal_clk(chal_clk_a), .chal_si(chal_si_a), .chal_so(chal_so_a)
  );

  logic [127:0] reg_a = '0;
  always @(posedge chal_clk_a) reg_a <= {reg_a[126:0], chal_si_a};
  assign chal_so_a = reg_a[127];
  int edges_a = 0;
  always @(posedge chal_clk_a) edges_a++;
  int dones_a = 0;
  always @(negedge clk) if (done_a) dones_a++;

  // 32-bit, DIV=3 build
  logic        rstn_b, wr_en_b, start_b, chal_so_b;
  logic [0:0]  wr_addr_b, rd_addr_b;
  logic [31:0] wr_data_b, rd_data_b;
  logic        busy_b, done_b, eval_b, chal_clk_b, chal_si_b;

  chal_load_ctrl #(.CHAL_BITS(32), .DIV(3), .EVAL_CYCLES(16), .AW(1)) u_dut_b (
    .clk(clk), .rstn(rstn_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .start(start_b), .busy(busy_b), .done(done_b),
    .eval(eval_b), .chal_clk(chal_clk_b), .chal_si(chal_si_b), .chal_so(chal_so_b)
  );

  logic [31:0] reg_b = '0;
  always @(posedge chal_clk_b) reg_b <= {reg_b[30:0], chal_si_b};
  assign chal_so_b = reg_b[31];
  int edges_b = 0;
  always @(posedge chal_clk_b) edges_b++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic write_a(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en_a = 1'b1; wr_addr_a = a; wr_data_a = d;
    @(negedge clk);
    wr_en_a = 1'b0;
  endtask

  task automatic check_rd_a(input string tag, input logic [127:0] exp);
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = 2'(i);
      #1;
      check_val($sformatf("%s_w%0d", tag, i), {96'd0, rd_data_a}, {96'd0, exp[i*32 +: 32]});
    end
  endtask

  // One start pulse on build A; returns cycles from the start edge until done is seen.
  task automatic run_a(input bit poke, input bit same_wr,
                       output int lat, output int evals, output logic first_si);
    bit seen;
    @(negedge clk);
    start_a = 1'b1;
    if (same_wr) begin
      wr_en_a = 1'b1; wr_addr_a = 2'd3; wr_data_a = 32'h8000_0000;
    end
    @(negedge clk);
    start_a = 1'b0; wr_en_a = 1'b0;
    lat = 0; evals = 0; seen = 1'b0; first_si = 1'b0;
    while (!done_a && lat < 400) begin
      if (eval_a) evals++;
      if (!seen && chal_clk_a) begin
        seen = 1'b1; first_si = chal_si_a;
      end
      if (poke && lat == 10) begin
        wr_en_a = 1'b1; wr_addr_a = 2'd0; wr_data_a = 32'hDEAD_BEEF; start_a = 1'b1;
      end else if (poke && lat == 11) begin
        wr_en_a = 1'b0; start_a = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    $display("[TB] seq A poke=%0d same_wr=%0d lat=%0d evals=%0d first_si=%0d", poke, same_wr, lat, evals, first_si);
  endtask

  localparam logic [127:0] PAT  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] ONES = {128{1'b1}};

  initial begin
    int lat, evals, e0, d0, k, bad_clk, bad_si;
    logic first_si, prev_clk, prev_si, exp_clk;

    rstn_a = 1'b0; wr_en_a = 1'b0; start_a = 1'b0; wr_addr_a = '0; wr_data_a = '0; rd_addr_a = '0;
    rstn_b = 1'b0; wr_en_b = 1'b0; start_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; rd_addr_b = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", {127'd0, busy_a}, 128'd0);
    check_val("rst_done", {127'd0, done_a}, 128'd0);
    check_val("rst_eval", {127'd0, eval_a}, 128'd0);
    check_val("rst_chal_clk", {127'd0, chal_clk_a}, 128'd0);
    check_val("rst_chal_si", {127'd0, chal_si_a}, 128'd0);
    rstn_a = 1'b1; rstn_b = 1'b1;
    check_rd_a("rst_rd", 128'd0);

    // Basic load
    for (int i = 0; i < 4; i++) write_a(2'(i), PAT[i*32 +: 32]);
    e0 = edges_a; d0 = dones_a;
    run_a(1'b0, 1'b0, lat, evals, first_si);
    check_val("basic_latency", 128'(lat), 128'd272);
    check_val("basic_eval_cycles", 128'(evals), 128'd16);
    check_val("basic_edges", 128'(edges_a - e0), 128'd128);
    check_val("basic_reg", reg_a, PAT);
    @(negedge clk);
    check_val("basic_done_pulse", {127'd0, done_a}, 128'd0);
    check_val("basic_idle_busy", {127'd0, busy_a}, 128'd0);
    check_val("basic_done_count", 128'(dones_a - d0), 128'd1);
    check_rd_a("basic_capture", 128'd0);

    // All-ones challenge with ignored traffic mid-sequence; capture shows previous challenge
    for (int i = 0; i < 4; i++) write_a(2'(i), 32'hFFFF_FFFF);
    e0 = edges_a; d0 = dones_a;
    run_a(1'b1, 1'b0, lat, evals, first_si);
    check_val("ign_latency", 128'(lat), 128'd272);
    check_val("ign_edges", 128'(edges_a - e0), 128'd128);
    check_val("ign_reg", reg_a, ONES);
    repeat (4) @(negedge clk);
    check_val("ign_done_count", 128'(dones_a - d0), 128'd1);
    check_val("ign_no_restart", {127'd0, busy_a}, 128'd0);
    check_rd_a("readback", PAT);

    // Repeat start re-sends the staged ones
    run_a(1'b0, 1'b0, lat, evals, first_si);
    check_val("repeat_reg", reg_a, ONES);
    check_rd_a("repeat_capture", ONES);
    @(negedge clk);

    // Same-cycle write and start: write lands first
    write_a(2'd3, 32'h0000_0000);
    run_a(1'b0, 1'b1, lat, evals, first_si);
    check_val("same_first_si", {127'd0, first_si}, 128'd1);
    check_val("same_reg", reg_a, {32'h8000_0000, 96'hFFFFFFFF_FFFFFFFF_FFFFFFFF});
    @(negedge clk);

    // Reset during SHIFT_HI
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    k = 0;
    while (!chal_clk_a && k < 10) begin
      @(negedge clk); k++;
    end
    check_val("midrst_reached_hi", {127'd0, chal_clk_a}, 128'd1);
    #2 rstn_a = 1'b0;
    #1;
    check_val("midrst_chal_clk", {127'd0, chal_clk_a}, 128'd0);
    check_val("midrst_busy", {127'd0, busy_a}, 128'd0);
    check_val("midrst_eval", {127'd0, eval_a}, 128'd0);
    @(negedge clk); rstn_a = 1'b1;
    check_rd_a("midrst_rd", 128'd0);

    // Divider build: DIV=3, 32 bits
    @(negedge clk); wr_en_b = 1'b1; wr_addr_b = 1'b0; wr_data_b = 32'hA5C3_0F96;
    @(negedge clk); wr_en_b = 1'b0; start_b = 1'b1;
    e0 = edges_b;
    @(negedge clk); start_b = 1'b0;
    k = 0; bad_clk = 0; bad_si = 0; prev_clk = 1'b0; prev_si = 1'b0;
    while (!done_b && k < 500) begin
      exp_clk = (k < 192) && (((k / 3) % 2) == 1);
      if (chal_clk_b !== exp_clk) bad_clk++;
      if (chal_clk_b && !prev_clk && (chal_si_b !== prev_si)) bad_si++;
      prev_clk = chal_clk_b; prev_si = chal_si_b;
      @(negedge clk); k++;
    end
    $display("[TB] seq B lat=%0d edges=%0d bad_clk=%0d bad_si=%0d", k, edges_b - e0, bad_clk, bad_si);
    check_val("div_latency", 128'(k), 128'd208);
    check_val("div_clk_pattern", 128'(bad_clk), 128'd0);
    check_val("div_si_stable", 128'(bad_si), 128'd0);
    check_val("div_edges", 128'(edges_b - e0), 128'd32);
    check_val("div_reg", {96'd0, reg_b}, {96'd0, 32'hA5C3_0F96});
    rd_addr_b = 1'b0; #1;
    check_val("div_capture", {96'd0, rd_data_b}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
